// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator.
//   led_mode_t : 2-bit pattern selector (OFF, BLINK, CHASE, BREATHE)
//   params_ok  : elaboration-time legality check of the generator parameters
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  // NUM_LEDS >= 1, TICK_DIV >= 1, PWM_BITS in 2..16.
  function automatic bit params_ok(input int num_leds, input int tick_div,
                                   input int pwm_bits);
    return (num_leds >= 1) && (tick_div >= 1) &&
           (pwm_bits >= 2) && (pwm_bits <= 16);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern generator.
//   en          : run enable (level; low freezes the generator)
//   mode        : requested pattern, sampled only on a tick
//   leds        : registered LED drive
//   tick        : one-cycle step strobe
//   mode_active : pattern currently in effect (exposes the pattern FSM state)
// There is no valid/ready handshake: en and mode are plain levels.
// master drives en/mode, slave (the generator) drives the rest.
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4
);
  logic                en;
  led_mode_t           mode;
  logic [NUM_LEDS-1:0] leds;
  logic                tick;
  led_mode_t           mode_active;

  modport master (output en, mode, input leds, tick, mode_active);
  modport slave  (input en, mode, output leds, tick, mode_active);
endinterface

// File: rtl/tick_prescaler.sv
// Enable-gated modulo-DIV counter producing a one-cycle strobe.
//   clk_in : clock
//   rst_n  : synchronous active-low reset
//   en     : count enable; the count holds while low
//   tick   : high in the enabled cycle where the count is DIV-1
module tick_prescaler #(
  parameter int DIV = 100_000_000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  // Gated by rst_n so the strobe is quiet while reset is held.
  assign tick    = rst_n & en & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = at_last ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF, alternate BLINK, bounce CHASE
// and PWM BREATHE, stepped by a prescaled tick.
//   clk_in, rst_n : clock and synchronous active-low reset
//   bus (slave)   : en/mode in; leds/tick/mode_active out
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic clk_in,
  input  logic rst_n,
  led_pattern_gen_if.slave bus
);
  if (!params_ok(NUM_LEDS, TICK_DIV, PWM_BITS)) begin : g_param_check
    $error("led_pattern_gen: illegal parameter set");
  end

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PW-1:0]       POS_ONE  = PW'(1);
  localparam logic [PW-1:0]       POS_LAST = PW'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic tick;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (bus.en),
    .tick   (tick)
  );

  led_mode_t           mode_active_q, mode_active_d;
  logic                phase_q, phase_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_up_q, duty_up_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  always_comb begin
    mode_active_d = mode_active_q;
    phase_d       = phase_q;
    pos_d         = pos_q;
    dir_up_d      = dir_up_q;
    duty_d        = duty_q;
    duty_up_d     = duty_up_q;
    pwm_cnt_d     = pwm_cnt_q;
    leds_d        = leds_q;

    if (bus.en) pwm_cnt_d = pwm_cnt_q + PWM_ONE;

    if (tick) begin
      if (bus.mode != mode_active_q) begin
        // Adoption tick: reinitialise only, no step.
        mode_active_d = bus.mode;
        phase_d       = 1'b0;
        pos_d         = '0;
        dir_up_d      = 1'b1;
        duty_d        = '0;
        duty_up_d     = 1'b1;
      end else begin
        case (mode_active_q)
          MODE_BLINK: phase_d = ~phase_q;
          MODE_CHASE: begin
            if (NUM_LEDS > 1) begin
              // Reverse at an end and move one step back in the same tick.
              if (dir_up_q) begin
                if (pos_q == POS_LAST) begin
                  dir_up_d = 1'b0;
                  pos_d    = pos_q - POS_ONE;
                end else begin
                  pos_d = pos_q + POS_ONE;
                end
              end else begin
                if (pos_q == '0) begin
                  dir_up_d = 1'b1;
                  pos_d    = pos_q + POS_ONE;
                end else begin
                  pos_d = pos_q - POS_ONE;
                end
              end
            end
          end
          MODE_BREATHE: begin
            if (duty_up_q) begin
              if (duty_q == DUTY_MAX) begin
                duty_up_d = 1'b0;
                duty_d    = duty_q - PWM_ONE;
              end else begin
                duty_d = duty_q + PWM_ONE;
              end
            end else begin
              if (duty_q == '0) begin
                duty_up_d = 1'b1;
                duty_d    = duty_q + PWM_ONE;
              end else begin
                duty_d = duty_q - PWM_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // LED drive is derived from the current (pre-step) state, so it lags
    // pattern state by one cycle.
    if (bus.en) begin
      case (mode_active_q)
        MODE_BLINK: begin
          for (int i = 0; i < NUM_LEDS; i++) leds_d[i] = phase_q ^ i[0];
        end
        MODE_CHASE:   leds_d = NUM_LEDS'(1) << pos_q;
        MODE_BREATHE: leds_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
        default:      leds_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      mode_active_q <= MODE_OFF;
      phase_q       <= 1'b0;
      pos_q         <= '0;
      dir_up_q      <= 1'b1;
      duty_q        <= '0;
      duty_up_q     <= 1'b1;
      pwm_cnt_q     <= '0;
      leds_q        <= '0;
    end else begin
      mode_active_q <= mode_active_d;
      phase_q       <= phase_d;
      pos_q         <= pos_d;
      dir_up_q      <= dir_up_d;
      duty_q        <= duty_d;
      duty_up_q     <= duty_up_d;
      pwm_cnt_q     <= pwm_cnt_d;
      leds_q        <= leds_d;
    end
  end

  assign bus.leds        = leds_q;
  assign bus.tick        = tick;
  assign bus.mode_active = mode_active_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a main instance (4 LEDs, div 4, 3-bit
// PWM), a breathe instance with a 16-cycle step, and a 1-LED/div-1 instance.
module tb_led_pattern_gen;
  import led_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.NUM_LEDS(4)) bus_m ();
  led_pattern_gen_if #(.NUM_LEDS(4)) bus_b ();
  led_pattern_gen_if #(.NUM_LEDS(1)) bus_e ();

  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(4), .PWM_BITS(3)) dut (
    .clk_in (clk), .rst_n (rst_n), .bus (bus_m));

  led_pattern_gen #(.NUM_LEDS(4), .TICK_DIV(16), .PWM_BITS(3)) dut_br (
    .clk_in (clk), .rst_n (rst_n), .bus (bus_b));

  led_pattern_gen #(.NUM_LEDS(1), .TICK_DIV(1), .PWM_BITS(3)) dut_edge (
    .clk_in (clk), .rst_n (rst_n), .bus (bus_e));

  // ---------------- driver tasks ----------------
  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stops in the cycle where tick is high (before the tick edge).
  task automatic wait_tick_m();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_m.tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_tick_m: tick=%b after 64 cycles, required 1", bus_m.tick);
    end
  endtask

  task automatic wait_tick_b();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_b.tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_tick_b: tick=%b after 64 cycles, required 1", bus_b.tick);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_m.en = 1'b1; bus_m.mode = MODE_BLINK;
    bus_e.en = 1'b1; bus_e.mode = MODE_CHASE;
    step(2);
    tests_run++;
    if (bus_m.leds !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_leds: got %b required 0000", bus_m.leds);
    end
    tests_run++;
    if (bus_m.tick !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tick: got %b required 0", bus_m.tick);
    end
    tests_run++;
    if (bus_m.mode_active !== MODE_OFF) begin
      tests_failed++; $display("FAIL reset_mode: got %0d required 0", bus_m.mode_active);
    end
    tests_run++;
    if (bus_e.tick !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tick_edge: got %b required 0", bus_e.tick);
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp_leds;
    rst_n = 1'b1;
    step(2);
    tests_run++;
    if (bus_m.tick !== 1'b0) begin
      tests_failed++; $display("FAIL blink_early_tick: got %b required 0", bus_m.tick);
    end
    step(1);
    tests_run++;
    if (bus_m.tick !== 1'b1 || bus_m.mode_active !== MODE_OFF) begin
      tests_failed++;
      $display("FAIL blink_first_tick: tick=%b mode=%0d required tick=1 mode=0",
               bus_m.tick, bus_m.mode_active);
    end
    step(1);
    tests_run++;
    if (bus_m.mode_active !== MODE_BLINK || bus_m.leds !== 4'b0000) begin
      tests_failed++;
      $display("FAIL blink_adopt: mode=%0d leds=%b required mode=1 leds=0000",
               bus_m.mode_active, bus_m.leds);
    end
    step(1);
    exp_leds = 4'b1010;
    tests_run++;
    if (bus_m.leds !== exp_leds) begin
      tests_failed++; $display("FAIL blink_entry: got %b required %b", bus_m.leds, exp_leds);
    end
    for (int k = 0; k < 4; k++) begin
      step(3);
      tests_run++;
      if (bus_m.leds !== exp_leds) begin
        tests_failed++; $display("FAIL blink_hold%0d: got %b required %b", k, bus_m.leds, exp_leds);
      end
      step(1);
      exp_leds = ~exp_leds;
      tests_run++;
      if (bus_m.leds !== exp_leds) begin
        tests_failed++; $display("FAIL blink_toggle%0d: got %b required %b", k, bus_m.leds, exp_leds);
      end
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010};
    bus_m.mode = MODE_CHASE;
    wait_tick_m();
    step(1);
    tests_run++;
    if (bus_m.mode_active !== MODE_CHASE) begin
      tests_failed++; $display("FAIL chase_adopt: got %0d required 2", bus_m.mode_active);
    end
    step(1);
    tests_run++;
    if (bus_m.leds !== 4'b0001) begin
      tests_failed++; $display("FAIL chase_entry: got %b required 0001", bus_m.leds);
    end
    for (int k = 0; k < 7; k++) begin
      wait_tick_m();
      step(2);
      tests_run++;
      if (bus_m.leds !== exp_seq[k]) begin
        tests_failed++; $display("FAIL chase_step%0d: got %b required %b", k, bus_m.leds, exp_seq[k]);
      end
    end
  endtask

  task automatic test_freeze();
    wait_tick_m();
    step(2);
    tests_run++;
    if (bus_m.leds !== 4'b0100) begin
      tests_failed++; $display("FAIL freeze_start: got %b required 0100", bus_m.leds);
    end
    bus_m.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      tests_run++;
      if (bus_m.leds !== 4'b0100 || bus_m.tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL freeze_hold%0d: leds=%b tick=%b required leds=0100 tick=0",
                 k, bus_m.leds, bus_m.tick);
      end
    end
    bus_m.en = 1'b1;
    step(1);
    tests_run++;
    if (bus_m.tick !== 1'b0) begin
      tests_failed++; $display("FAIL resume_early: tick=%b required 0", bus_m.tick);
    end
    step(1);
    tests_run++;
    if (bus_m.tick !== 1'b1) begin
      tests_failed++; $display("FAIL resume_tick: tick=%b required 1", bus_m.tick);
    end
    step(2);
    tests_run++;
    if (bus_m.leds !== 4'b1000) begin
      tests_failed++; $display("FAIL resume_step: got %b required 1000", bus_m.leds);
    end
  endtask

  task automatic test_mode_change_reset();
    bus_m.mode = MODE_BLINK;
    step(1);
    tests_run++;
    if (bus_m.mode_active !== MODE_CHASE || bus_m.leds !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mc_between: mode=%0d leds=%b required mode=2 leds=1000",
               bus_m.mode_active, bus_m.leds);
    end
    step(1);
    tests_run++;
    if (bus_m.tick !== 1'b1 || bus_m.mode_active !== MODE_CHASE) begin
      tests_failed++;
      $display("FAIL mc_tick: tick=%b mode=%0d required tick=1 mode=2",
               bus_m.tick, bus_m.mode_active);
    end
    step(1);
    tests_run++;
    if (bus_m.mode_active !== MODE_BLINK || bus_m.leds !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mc_adopt: mode=%0d leds=%b required mode=1 leds=1000",
               bus_m.mode_active, bus_m.leds);
    end
    step(1);
    tests_run++;
    if (bus_m.leds !== 4'b1010) begin
      tests_failed++; $display("FAIL mc_leds: got %b required 1010", bus_m.leds);
    end
    rst_n = 1'b0;
    step(1);
    tests_run++;
    if (bus_m.leds !== 4'b0000 || bus_m.mode_active !== MODE_OFF) begin
      tests_failed++;
      $display("FAIL mid_reset: leds=%b mode=%0d required leds=0000 mode=0",
               bus_m.leds, bus_m.mode_active);
    end
    rst_n = 1'b1;
  endtask

  // With a 16-cycle step every duty value is seen over 16 consecutive PWM
  // counts, i.e. two full 8-count periods: expected high count is 2*duty.
  task automatic test_breathe();
    int exp_duty [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int hi;
    int bad;
    bus_b.mode = MODE_BREATHE;
    bus_b.en   = 1'b1;
    wait_tick_b();
    step(1);
    tests_run++;
    if (bus_b.mode_active !== MODE_BREATHE) begin
      tests_failed++; $display("FAIL br_adopt: got %0d required 3", bus_b.mode_active);
    end
    for (int w = 0; w < 15; w++) begin
      hi  = 0;
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        step(1);
        if (bus_b.leds === 4'b1111)      hi++;
        else if (bus_b.leds !== 4'b0000) bad++;
      end
      tests_run++;
      if (hi != 2 * exp_duty[w] || bad != 0) begin
        tests_failed++;
        $display("FAIL br_duty%0d: high=%0d split=%0d required high=%0d split=0",
                 w, hi, bad, 2 * exp_duty[w]);
      end
    end
  endtask

  task automatic test_edge_params();
    step(3);
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (bus_e.tick !== 1'b1 || bus_e.leds !== 1'b1 || bus_e.mode_active !== MODE_CHASE) begin
        tests_failed++;
        $display("FAIL edge%0d: tick=%b leds=%b mode=%0d required tick=1 leds=1 mode=2",
                 k, bus_e.tick, bus_e.leds, bus_e.mode_active);
      end
      step(1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus_m.en = 1'b0; bus_m.mode = MODE_OFF;
    bus_b.en = 1'b0; bus_b.mode = MODE_OFF;
    bus_e.en = 1'b0; bus_e.mode = MODE_OFF;
    step(1);
    test_reset();
    test_blink();
    test_chase();
    test_freeze();
    test_mode_change_reset();
    test_breathe();
    test_edge_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
